// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: fetch-to-decode instruction buffer with flush and HALT intake block; define FDQ_BYPASS_EN for empty-queue bypass
module fetch_decode_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] NOP_WORD = 16'h0800,
  parameter logic [4:0]  HALT_OP  = 5'b00000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  input  logic [15:0]              in_pc2,
  input  logic                     in_err,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_instr,
  output logic [15:0]              out_pc2,
  output logic                     out_err,
  input  logic                     out_ready,
  output logic                     halt_held,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [15:0]   instr_q [DEPTH];
  logic [15:0]   pc2_q   [DEPTH];
  logic          err_q   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          head_valid, byp, take, enq, deq;
  always_comb begin
    in_ready   = (count < FULL) & ~halt_held;
    head_valid = count != '0;
`ifdef FDQ_BYPASS_EN
    byp        = ~head_valid & in_valid & in_ready & ~flush;
`else
    byp        = 1'b0;
`endif
    take       = in_valid & in_ready & ~flush;
    enq        = take & ~(byp & out_ready);
    deq        = head_valid & out_ready & ~flush;
    out_valid  = head_valid | byp;
    out_instr  = byp ? in_instr : head_valid ? instr_q[rd_ptr] : NOP_WORD;
    out_pc2    = byp ? in_pc2   : head_valid ? pc2_q[rd_ptr]   : 16'h0000;
    out_err    = byp ? in_err   : head_valid & err_q[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_held <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc2_q[i]   <= '0;
        err_q[i]   <= 1'b0;
      end
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_held <= 1'b0;
    end else begin
      if (enq) begin
        instr_q[wr_ptr] <= in_instr;
        pc2_q[wr_ptr]   <= in_pc2;
        err_q[wr_ptr]   <= in_err;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
      if (take && in_instr[15:11] == HALT_OP) halt_held <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed and random stimulus checked against a queue-based reference model
module tb_fetch_decode_queue;
  localparam int DEPTH = 2;
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        err;
  } ent_t;
  logic clk = 1'b0, rst, flush, in_valid, in_err, in_ready, out_valid, out_err, out_ready, halt_held;
  logic [15:0] in_instr, in_pc2, out_instr, out_pc2;
  logic [1:0]  count;
  ent_t q[$];
  logic m_halt = 1'b0;
  int nvec = 0, nerr = 0;

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_instr(in_instr),
    .in_pc2(in_pc2), .in_err(in_err), .in_ready(in_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc2(out_pc2), .out_err(out_err), .out_ready(out_ready),
    .halt_held(halt_held), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic rdy, byp, take, vld;
    logic [15:0] ei, ep;
    logic ee;
    rdy = (q.size() < DEPTH) && !m_halt;
`ifdef FDQ_BYPASS_EN
    byp = (q.size() == 0) && in_valid && rdy && !flush;
`else
    byp = 1'b0;
`endif
    take = in_valid && rdy && !flush;
    vld  = (q.size() > 0) || byp;
    ei = byp ? in_instr : (q.size() > 0) ? q[0].instr : 16'h0800;
    ep = byp ? in_pc2   : (q.size() > 0) ? q[0].pc2   : 16'h0000;
    ee = byp ? in_err   : (q.size() > 0) ? q[0].err   : 1'b0;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("out_valid", 32'(out_valid), 32'(vld));
    chk("out_instr", 32'(out_instr), 32'(ei));
    chk("out_pc2", 32'(out_pc2), 32'(ep));
    chk("out_err", 32'(out_err), 32'(ee));
    chk("count", 32'(count), 32'(q.size()));
    chk("halt_held", 32'(halt_held), 32'(m_halt));
    if (rst || flush) begin
      q.delete();
      m_halt = 1'b0;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (take && !(byp && out_ready)) q.push_back('{in_instr, in_pc2, in_err});
      if (take && in_instr[15:11] == 5'b00000) m_halt = 1'b1;
    end
  endtask

  task automatic cyc(input logic r, f, v, input logic [15:0] i, p, input logic e, o);
    rst = r; flush = f; in_valid = v; in_instr = i; in_pc2 = p; in_err = e; out_ready = o;
    #2;
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc2 = '0; in_err = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0);
    cyc(1, 0, 0, 16'h0, 16'h0, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_instr", 32'(out_instr), 32'h0800);
    chk("rst_ready", 32'(in_ready), 32'd1);
    cyc(0, 0, 1, 16'hA001, 16'h0002, 0, 0);
    cyc(0, 0, 1, 16'hA002, 16'h0004, 1, 0);
    chk("full_count", 32'(count), 32'd2);
    chk("full_ready", 32'(in_ready), 32'd0);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 1);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 1);
    chk("drain_count", 32'(count), 32'd0);
    cyc(0, 0, 1, 16'hA003, 16'h0006, 0, 0);
    cyc(0, 0, 1, 16'hA004, 16'h0008, 0, 0);
    cyc(0, 0, 1, 16'hC003, 16'h000A, 0, 1);
    chk("full_deq_count", 32'(count), 32'd1);
    cyc(0, 0, 1, 16'hC003, 16'h000A, 0, 0);
    chk("reenq_count", 32'(count), 32'd2);
    cyc(0, 1, 1, 16'hBEEF, 16'h000C, 0, 0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_instr", 32'(out_instr), 32'h0800);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 0);
    chk("no_beef", 32'(out_instr), 32'h0800);
    cyc(0, 0, 1, 16'h0000, 16'h000E, 0, 0);
    chk("halt_set", 32'(halt_held), 32'd1);
    cyc(0, 0, 0, 16'h0, 16'h0, 0, 1);
    chk("halt_drain_ready", 32'(in_ready), 32'd0);
    cyc(0, 1, 0, 16'h0, 16'h0, 0, 0);
    chk("halt_clr", 32'(halt_held), 32'd0);
    chk("halt_clr_ready", 32'(in_ready), 32'd1);
`ifdef FDQ_BYPASS_EN
    rst = 0; flush = 0; in_valid = 1; in_instr = 16'h1234; in_pc2 = 16'h0010; in_err = 0; out_ready = 1;
    #1;
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_instr", 32'(out_instr), 32'h1234);
    cyc(0, 0, 1, 16'h1234, 16'h0010, 0, 1);
    chk("byp_count", 32'(count), 32'd0);
`endif
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] w;
      w = 16'($urandom());
      if ($urandom_range(0, 9) == 0) w[15:11] = 5'b00000;
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, 1'($urandom()), w,
          16'($urandom()), 1'($urandom()), 1'($urandom()));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
